pwm_output_stage: RTL and testbench
===================================

# pwm_output_stage

Drives the 16 user output pins from the control registers written over SPI. Consumes `en_reg_out_7_0`, `en_reg_out_15_8`, `en_reg_pwm_7_0`, `en_reg_pwm_15_8` and `pwm_duty_cycle` from the SPI register block and produces per-pin static-high, static-low or PWM waveforms. It contains a clock prescaler and an 8-bit period counter, shared by all channels.

## Interface
- `CLK_DIV`, default 3000: clocks per PWM counter step; legal range 1..65535.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `en_reg_out_7_0` input 8: output enable, pins 7..0.
- `en_reg_out_15_8` input 8: output enable, pins 15..8.
- `en_reg_pwm_7_0` input 8: PWM mode select, pins 7..0.
- `en_reg_pwm_15_8` input 8: PWM mode select, pins 15..8.
- `pwm_duty_cycle` input 8: shared duty value; 0 = 0 %, 255 = 100 %.
- `out` output 16: pin drive; bit i = pin i.
- `period_start` output 1: one-cycle pulse at the first clock of each PWM period.

## Operation
- Prescaler `div_cnt`, 16 bits, counts 0..CLK_DIV-1 and then wraps to 0.
  - `tick` = (`div_cnt` == CLK_DIV-1).
  - With CLK_DIV=1, `tick` is high every cycle.
- PWM counter `pwm_cnt`, 8 bits, increments on `tick`.
  - 255 wraps to 0.
  - Period = 256*CLK_DIV clocks.
- `wrap` = `tick` && `pwm_cnt`==255.
- PWM level: `level` = 1 if effective duty == 255, else (`pwm_cnt` < effective duty).
  - Duty 0 gives constant 0.
  - Duty d (1..254) gives exactly d*CLK_DIV high clocks per period, starting at `pwm_cnt`=0.
- Per pin i, with `en_out` = {en_reg_out_15_8, en_reg_out_7_0} and `en_pwm` = effective PWM select:
  - `en_out[i]`=0 gives 0, regardless of `en_pwm[i]`.
  - `en_out[i]`=1, `en_pwm[i]`=0 gives 1.
  - `en_out[i]`=1, `en_pwm[i]`=1 gives `level`.
- `out` and `period_start` are registered.
  - `period_start` is asserted in the cycle where `pwm_cnt` first equals 0 after a wrap.
  - `period_start` is also asserted in the first cycle after reset release.
- Effective duty and effective `en_pwm` come from live inputs or from shadow registers; see Configuration.
- `en_out` is always used live.

## Timing
- All state updates on rising `clk`.
- Reset: sampled at a rising edge with `rst_n`=0. The following all become 0 on that edge:
  - `div_cnt`, `pwm_cnt`, `out`, `period_start`, shadow registers.
- Reset asserted mid-period: the waveform is aborted. After release the counters restart from 0, with no partial-period carry-over.
- Latency: a change on any live input at edge k (setup satisfied) appears on `out` after edge k+1. That is one register stage.
- `pwm_cnt` advances on the edge where `tick`=1. `out` reflects the new `pwm_cnt` one edge later.
- Input change coincident with `wrap`: the new input value is the one taken; no mix of old and new values is permitted.
- Inputs are synchronous to `clk`; no synchronizers are needed in this block.

## Configuration
- Macro: `PWM_SHADOW_EN`.
- Defined:
  - `pwm_duty_cycle` and both `en_reg_pwm` bytes are copied into shadow registers on the edge where `wrap`=1.
  - The shadows are also loaded on the first edge after reset release.
  - Effective duty and `en_pwm` come from the shadows, so SPI writes take effect only at the next period boundary. This guarantees no truncated or runt pulses.
- Not defined:
  - No shadow registers exist.
  - Effective values are the live inputs, so a duty change applies within one clock, mid-period.

## Test plan
- Reset, CLK_DIV=4, all inputs 0, hold 2000 clocks -> `out`=16'h0000 throughout; `period_start` pulses every 1024 clocks.
- `en_out`=16'hFFFF, `en_pwm`=0 -> `out`=16'hFFFF one clock after the write; duty changes have no effect.
- CLK_DIV=4, `en_out`=`en_pwm`=16'h0001, duty=128 -> pin 0 high exactly 512 of every 1024 clocks, rising on the clock after `period_start`; pins 15..1 stay 0.
- Duty 0 -> pin 0 constantly 0. Duty 255 -> pin 0 constantly 1 across 3 full periods. Duty 1 -> high exactly 4 clocks per period.
- With `PWM_SHADOW_EN`, change duty 64→192 at `pwm_cnt`=100 -> current period keeps 256 high clocks; next period has 768.
  - Without the macro, high time changes within 2 clocks of the write.
- Assert `rst_n`=0 for 1 clock at `pwm_cnt`=200 with PWM active -> `out`=0 on the next edge; after release the counters restart at 0 and `period_start` pulses once.

Source files
------------

// File: rtl/pwm_output_stage.sv
// Per-pin static-high / static-low / PWM drive for 16 output pins. Optional macro PWM_SHADOW_EN latches duty and PWM select at period boundaries.
// Latency: one register stage from any input to out; free-running, no backpressure.
module pwm_output_stage #(
   parameter int unsigned CLK_DIV = 3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

   logic [15:0] div_cnt;
   logic [7:0]  pwm_cnt;
   logic        started;
   logic        tick;
   logic        wrap;
   logic        level;
   logic [15:0] en_out;
   logic [15:0] en_pwm_live;
   logic [15:0] en_pwm_eff;
   logic [7:0]  duty_eff;
   logic [15:0] out_nxt;

   assign tick        = (div_cnt == DIV_MAX);
   assign wrap        = tick && (pwm_cnt == 8'hFF);
   assign en_out      = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm_live = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_SHADOW_EN
   logic [15:0] en_pwm_sh;
   logic [7:0]  duty_sh;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_pwm_sh <= '0;
         duty_sh   <= '0;
      end else if (wrap || !started) begin
         en_pwm_sh <= en_pwm_live;
         duty_sh   <= pwm_duty_cycle;
      end
   end

   // Shadows still hold their reset value on the first edge after release,
   // so that single edge takes the live values directly.
   assign en_pwm_eff = started ? en_pwm_sh : en_pwm_live;
   assign duty_eff   = started ? duty_sh   : pwm_duty_cycle;
`else
   assign en_pwm_eff = en_pwm_live;
   assign duty_eff   = pwm_duty_cycle;
`endif

   assign level   = (duty_eff == 8'hFF) || (pwm_cnt < duty_eff);
   assign out_nxt = en_out & (~en_pwm_eff | {16{level}});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt      <= '0;
         pwm_cnt      <= '0;
         started      <= 1'b0;
         out          <= '0;
         period_start <= 1'b0;
      end else begin
         div_cnt      <= tick ? 16'd0 : div_cnt + 16'd1;
         if (tick)
            pwm_cnt   <= pwm_cnt + 8'd1;
         started      <= 1'b1;
         out          <= out_nxt;
         period_start <= wrap || !started;
      end
   end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with CLK_DIV=4 (period = 1024 clocks).
module tb_pwm_output_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        period_start;

   int vec  = 0;
   int errs = 0;
   int n    = 0;   // edges since reset release
   int highs;

   pwm_output_stage #(.CLK_DIV(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (out),
      .period_start    (period_start)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   // pwm_cnt value seen before edge n (n >= 1)
   function automatic int pre_cnt();
      return ((n - 1) / 4) % 256;
   endfunction

   function automatic logic lvl(input int p, input int d);
      return (d == 255) || (p < d);
   endfunction

   task automatic wait_ps(input string tag);
      int k = 0;
      do begin
         step();
         k++;
      end while (!period_start && k < 1100);
      chk(tag, period_start, 1'b1);
   endtask

   task automatic apply_cfg(input string tag);
`ifdef PWM_SHADOW_EN
      wait_ps(tag);
`endif
      step();
   endtask

   task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
      {en_reg_out_15_8, en_reg_out_7_0} = eo;
      {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
      pwm_duty_cycle = d;
   endtask

   task automatic run_period(input int d, input string tag, output int h);
      h = 0;
      for (int i = 0; i < 1024; i++) begin
         step();
         chk({tag, "_out"}, {16'h0, out}, {31'h0, lvl(pre_cnt(), d)});
         chk({tag, "_ps"}, {31'h0, period_start}, {31'h0, (n % 1024) == 0});
         if (out[0]) h++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      set_cfg(16'h0000, 16'h0000, 8'd0);
      step();
      step();
      chk("rst_out", {16'h0, out}, 32'h0);
      chk("rst_ps", {31'h0, period_start}, 32'h0);

      // All inputs zero: pins low, period_start at release and every 1024 clocks
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         step();
         chk("idle_out", {16'h0, out}, 32'h0);
         chk("idle_ps", {31'h0, period_start}, {31'h0, (n == 1) || (n % 1024 == 0)});
      end

      // Static high on every pin; duty irrelevant
      set_cfg(16'hFFFF, 16'h0000, 8'd0);
      step();
      chk("static_hi", {16'h0, out}, 32'hFFFF);
      pwm_duty_cycle = 8'd77;
      step();
      chk("static_hi_d77", {16'h0, out}, 32'hFFFF);
      pwm_duty_cycle = 8'd255;
      step();
      chk("static_hi_d255", {16'h0, out}, 32'hFFFF);

      // Mixed modes at the duty extremes
      set_cfg(16'hA5C3, 16'h00FF, 8'd255);
      apply_cfg("align_mix1");
      chk("mix_d255", {16'h0, out}, 32'hA5C3);
      set_cfg(16'hA5C3, 16'h00FF, 8'd0);
      apply_cfg("align_mix2");
      chk("mix_d0", {16'h0, out}, 32'hA500);
      set_cfg(16'h0000, 16'hFFFF, 8'd255);
      step();
      chk("en_out_off", {16'h0, out}, 32'h0);

      // Pin 0 PWM at duty 128
      set_cfg(16'h0001, 16'h0001, 8'd128);
      wait_ps("align_d128");
      chk("d128_ps_edge", {16'h0, out}, 32'h0);
      run_period(128, "d128", highs);
      chk("d128_highs", highs, 512);

      pwm_duty_cycle = 8'd255;
      wait_ps("align_d255");
      for (int r = 0; r < 3; r++) begin
         run_period(255, "d255", highs);
         chk("d255_highs", highs, 1024);
      end

      pwm_duty_cycle = 8'd0;
      wait_ps("align_d0");
      run_period(0, "d0", highs);
      chk("d0_highs", highs, 0);

      pwm_duty_cycle = 8'd1;
      wait_ps("align_d1");
      run_period(1, "d1", highs);
      chk("d1_highs", highs, 4);

      // Duty 64 -> 192 written when pwm_cnt reaches 100
      pwm_duty_cycle = 8'd64;
      wait_ps("align_d64");
      highs = 0;
      for (int k = 1; k <= 1024; k++) begin
         step();
         if (k == 400) pwm_duty_cycle = 8'd192;
`ifdef PWM_SHADOW_EN
         if (k == 401) chk("chg_edge", {31'h0, out[0]}, 32'h0);
`else
         if (k == 401) chk("chg_edge", {31'h0, out[0]}, 32'h1);
`endif
         if (out[0]) highs++;
      end
`ifdef PWM_SHADOW_EN
      chk("chg_highs", highs, 256);
`else
      chk("chg_highs", highs, 624);
`endif
      run_period(192, "d192", highs);
      chk("d192_highs", highs, 768);

      // Reset pulse at pwm_cnt = 200 aborts the period
      for (int k = 0; k < 800; k++) step();
      rst_n = 1'b0;
      step();
      chk("midrst_out", {16'h0, out}, 32'h0);
      chk("midrst_ps", {31'h0, period_start}, 32'h0);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 1024; i++) begin
         step();
         chk("post_rst_out", {16'h0, out}, {31'h0, lvl(pre_cnt(), 192)});
         chk("post_rst_ps", {31'h0, period_start}, {31'h0, (n == 1) || (n == 1024)});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
